// File: rtl/axilite_noc_pkg.sv
// Shared types, message field layout and helpers for the AXI-lite to NoC request packetizer.
// Field positions follow the define.tmp.h header layout (3 x 64-bit header flits).
package axilite_noc_pkg;

    localparam int NOC_DATA_WIDTH = 64;
    localparam int PHY_ADDR_WIDTH = 40;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_HDR2 = 3'd3,
        ST_DATA = 3'd4
    } state_e;

    localparam logic [1:0] TAG_LOAD  = 2'd1;
    localparam logic [1:0] TAG_STORE = 2'd2;

    localparam int LOAD_FLITS  = 3;
    localparam int STORE_FLITS = 4;

    localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ  = 8'd14;
    localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15;
    // MSG_LENGTH counts flits after header0
    localparam logic [7:0] MSG_LENGTH_LOAD  = 8'(LOAD_FLITS - 1);
    localparam logic [7:0] MSG_LENGTH_STORE = 8'(STORE_FLITS - 1);

    localparam logic [2:0] MSG_DATA_SIZE_1B = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B = 3'b011;
    localparam logic [2:0] MSG_DATA_SIZE_8B = 3'b100;

    localparam int MSG_CHIPID_HI = 63, MSG_CHIPID_LO = 50;
    localparam int MSG_XPOS_HI   = 49, MSG_XPOS_LO   = 42;
    localparam int MSG_YPOS_HI   = 41, MSG_YPOS_LO   = 34;
    localparam int MSG_LENGTH_HI = 29, MSG_LENGTH_LO = 22;
    localparam int MSG_TYPE_HI   = 21, MSG_TYPE_LO   = 14;
    localparam int MSG_MSHRID_HI = 13, MSG_MSHRID_LO = 6;
    localparam int MSG_ADDR_HI   = 47, MSG_ADDR_LO   = 8;
    localparam int MSG_SIZE_HI   = 58, MSG_SIZE_LO   = 56;

    typedef struct packed {
        logic [2:0] size;
        logic [2:0] offset;
    } mask_t;

    // Contiguous aligned strobes shrink the access; anything else is a full 8B write.
    function automatic mask_t strb_to_mask(input logic [7:0] strb);
        mask_t m;
        logic [2:0] low;
        m.size   = MSG_DATA_SIZE_8B;
        m.offset = 3'd0;
        low      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (strb[i]) low = 3'(i);
        end
        case (strb)
            8'h0F, 8'hF0: begin
                m.size   = MSG_DATA_SIZE_4B;
                m.offset = low;
            end
            8'h03, 8'h0C, 8'h30, 8'hC0: begin
                m.size   = MSG_DATA_SIZE_2B;
                m.offset = low;
            end
            8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: begin
                m.size   = MSG_DATA_SIZE_1B;
                m.offset = low;
            end
            default: ;
        endcase
        return m;
    endfunction

    // Byte 0 lands in [63:56], undone by the response-path swap.
    function automatic logic [63:0] byte_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[63-8*i -: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axilite_noc_hdr_gen.sv
// Combinational builder for the three NoC header flits of a non-cacheable load/store.
module axilite_noc_hdr_gen
    import axilite_noc_pkg::*;
#(
    parameter logic [13:0] DEST_CHIPID = '0,
    parameter logic [7:0]  DEST_X      = '0,
    parameter logic [7:0]  DEST_Y      = '0,
    parameter logic [13:0] SRC_CHIPID  = '0,
    parameter logic [7:0]  SRC_X       = '0,
    parameter logic [7:0]  SRC_Y       = '0
) (
    input  logic                      is_store,
    input  logic [PHY_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                size,
    output logic [NOC_DATA_WIDTH-1:0] hdr0,
    output logic [NOC_DATA_WIDTH-1:0] hdr1,
    output logic [NOC_DATA_WIDTH-1:0] hdr2
);

    always_comb begin
        hdr0 = '0;
        hdr0[MSG_CHIPID_HI:MSG_CHIPID_LO] = DEST_CHIPID;
        hdr0[MSG_XPOS_HI:MSG_XPOS_LO]     = DEST_X;
        hdr0[MSG_YPOS_HI:MSG_YPOS_LO]     = DEST_Y;
        hdr0[MSG_LENGTH_HI:MSG_LENGTH_LO] = is_store ? MSG_LENGTH_STORE : MSG_LENGTH_LOAD;
        hdr0[MSG_TYPE_HI:MSG_TYPE_LO]     = is_store ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;
        hdr0[MSG_MSHRID_HI:MSG_MSHRID_LO] = '0;

        hdr1 = '0;
        hdr1[MSG_ADDR_HI:MSG_ADDR_LO] = addr;
        hdr1[MSG_SIZE_HI:MSG_SIZE_LO] = size;

        hdr2 = '0;
        hdr2[MSG_CHIPID_HI:MSG_CHIPID_LO] = SRC_CHIPID;
        hdr2[MSG_XPOS_HI:MSG_XPOS_LO]     = SRC_X;
        hdr2[MSG_YPOS_HI:MSG_YPOS_LO]     = SRC_Y;
    end

endmodule

// File: rtl/axilite_noc_request.sv
// AXI-lite slave to NoC non-cacheable load/store packetizer with response-tag push.
// AXILITE_NOC_REQ_BYTEMASK_EN: derive store size/address low bits from wstrb.
module axilite_noc_request
    import axilite_noc_pkg::*;
#(
    parameter int          AXI_LITE_DATA_WIDTH = 64,
    parameter int          AXI_LITE_ADDR_WIDTH = 64,
    parameter int          AXI_LITE_RESP_WIDTH = 2,
    parameter logic [13:0] DEST_CHIPID         = '0,
    parameter logic [7:0]  DEST_X              = '0,
    parameter logic [7:0]  DEST_Y              = '0,
    parameter logic [13:0] SRC_CHIPID          = '0,
    parameter logic [7:0]  SRC_X               = '0,
    parameter logic [7:0]  SRC_Y               = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic                             noc_valid_out,
    output logic [NOC_DATA_WIDTH-1:0]        noc_data_out,
    input  logic                             noc_ready_in,
    output logic [2:0]                       transaction_type_wr_data,
    output logic                             transaction_type_wr,
    input  logic                             type_fifo_full
);

    localparam int PW = PHY_ADDR_WIDTH;
    localparam int unused_resp_w = AXI_LITE_RESP_WIDTH;

    state_e              state_q, state_d;
    logic                ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                ar_ready_q, ar_ready_d, aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
    logic [PW-1:0]       ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [63:0]         w_data_q, w_data_d;
    logic [7:0]          w_strb_q, w_strb_d;
    logic                rr_q, rr_d;
    logic                is_store_q, is_store_d;
    logic [PW-1:0]       addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [63:0]         data_q, data_d;
    logic                noc_valid_q, noc_valid_d;
    logic [63:0]         noc_data_q, noc_data_d;

    logic                rd_cand, wr_cand, pick_wr, grant;
    logic [PW-1:0]       base_addr;
    mask_t               mask;
    logic                sel_store;
    logic [PW-1:0]       sel_addr;
    logic [2:0]          sel_size;
    logic [63:0]         hdr0, hdr1, hdr2;

    // Arbitration and the fields a grant would latch; headers see them in IDLE.
    always_comb begin
        rd_cand   = ar_valid_q;
        wr_cand   = aw_valid_q && w_valid_q;
        pick_wr   = wr_cand && (!rd_cand || rr_q);
        base_addr = pick_wr ? aw_addr_q : ar_addr_q;
        grant     = (state_q == ST_IDLE) && !type_fifo_full && (rd_cand || wr_cand);
`ifdef AXILITE_NOC_REQ_BYTEMASK_EN
        mask = pick_wr ? strb_to_mask(w_strb_q) : '{MSG_DATA_SIZE_8B, 3'd0};
`else
        mask = '{MSG_DATA_SIZE_8B, 3'd0};
`endif
        if (state_q == ST_IDLE) begin
            sel_store = pick_wr;
            sel_addr  = {base_addr[PW-1:3], mask.offset};
            sel_size  = mask.size;
        end else begin
            sel_store = is_store_q;
            sel_addr  = addr_q;
            sel_size  = size_q;
        end
    end

    axilite_noc_hdr_gen #(
        .DEST_CHIPID (DEST_CHIPID),
        .DEST_X      (DEST_X),
        .DEST_Y      (DEST_Y),
        .SRC_CHIPID  (SRC_CHIPID),
        .SRC_X       (SRC_X),
        .SRC_Y       (SRC_Y)
    ) u_hdr_gen (
        .is_store (sel_store),
        .addr     (sel_addr),
        .size     (sel_size),
        .hdr0     (hdr0),
        .hdr1     (hdr1),
        .hdr2     (hdr2)
    );

    always_comb begin
        state_d     = state_q;
        ar_valid_d  = ar_valid_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_addr_d   = ar_addr_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        rr_d        = rr_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        size_d      = size_q;
        data_d      = data_q;
        noc_valid_d = noc_valid_q;
        noc_data_d  = noc_data_q;

        if (s_axi_arvalid && ar_ready_q) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = s_axi_araddr[PW-1:0];
        end
        if (s_axi_awvalid && aw_ready_q) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = s_axi_awaddr[PW-1:0];
        end
        if (s_axi_wvalid && w_ready_q) begin
            w_valid_d = 1'b1;
            w_data_d  = s_axi_wdata;
            w_strb_d  = s_axi_wstrb;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d     = ST_HDR0;
                    is_store_d  = sel_store;
                    addr_d      = sel_addr;
                    size_d      = sel_size;
                    data_d      = byte_swap64(w_data_q);
                    rr_d        = !pick_wr;
                    noc_valid_d = 1'b1;
                    noc_data_d  = hdr0;
                end
            end
            ST_HDR0: begin
                if (noc_ready_in) begin
                    state_d    = ST_HDR1;
                    noc_data_d = hdr1;
                end
            end
            ST_HDR1: begin
                if (noc_ready_in) begin
                    state_d    = ST_HDR2;
                    noc_data_d = hdr2;
                end
            end
            ST_HDR2: begin
                if (noc_ready_in) begin
                    if (is_store_q) begin
                        state_d    = ST_DATA;
                        noc_data_d = data_q;
                    end else begin
                        state_d     = ST_IDLE;
                        noc_valid_d = 1'b0;
                        noc_data_d  = '0;
                        ar_valid_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (noc_ready_in) begin
                    state_d     = ST_IDLE;
                    noc_valid_d = 1'b0;
                    noc_data_d  = '0;
                    aw_valid_d  = 1'b0;
                    w_valid_d   = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                noc_valid_d = 1'b0;
                noc_data_d  = '0;
            end
        endcase

        // Ready tracks the next buffer state so it is registered yet never stale.
        ar_ready_d = !ar_valid_d;
        aw_ready_d = !aw_valid_d;
        w_ready_d  = !w_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_ready_q  <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            ar_addr_q   <= '0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            rr_q        <= 1'b0;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            noc_valid_q <= 1'b0;
            noc_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= ar_valid_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_ready_q  <= ar_ready_d;
            aw_ready_q  <= aw_ready_d;
            w_ready_q   <= w_ready_d;
            ar_addr_q   <= ar_addr_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            rr_q        <= rr_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            noc_valid_q <= noc_valid_d;
            noc_data_q  <= noc_data_d;
        end
    end

    assign s_axi_arready = ar_ready_q;
    assign s_axi_awready = aw_ready_q;
    assign s_axi_wready  = w_ready_q;
    assign noc_valid_out = noc_valid_q;
    assign noc_data_out  = noc_data_q;

    assign transaction_type_wr      = grant && !rst;
    assign transaction_type_wr_data = (grant && !rst) ?
                                      {pick_wr ? TAG_STORE : TAG_LOAD, base_addr[3]} : 3'b000;

    logic unused_bits;
`ifdef AXILITE_NOC_REQ_BYTEMASK_EN
    assign unused_bits = ^{s_axi_araddr[AXI_LITE_ADDR_WIDTH-1:PW], s_axi_awaddr[AXI_LITE_ADDR_WIDTH-1:PW],
                           base_addr[2:0]};
`else
    assign unused_bits = ^{s_axi_araddr[AXI_LITE_ADDR_WIDTH-1:PW], s_axi_awaddr[AXI_LITE_ADDR_WIDTH-1:PW],
                           base_addr[2:0], w_strb_q};
`endif

endmodule

// File: tb/tb_axilite_noc_request.sv
// Directed self-checking bench for axilite_noc_request (load/store packets, arbitration, backpressure).
module tb_axilite_noc_request;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_arvalid, s_axi_arready, s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic        noc_valid_out, noc_ready_in, transaction_type_wr, type_fifo_full;
    logic [63:0] noc_data_out;
    logic [2:0]  transaction_type_wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] flits[$];
    int          flit_cyc[$];
    logic [2:0]  tags[$];
    int          tag_cyc[$];

    // Hand-derived flits for DEST 3/1/2, SRC 5/4/6
    localparam logic [63:0] H0_LOAD  = 64'h000C_0408_0083_8000;
    localparam logic [63:0] H0_STORE = 64'h000C_0408_00C3_C000;
    localparam logic [63:0] H2       = 64'h0014_1018_0000_0000;

    axilite_noc_request #(
        .AXI_LITE_DATA_WIDTH (64),
        .AXI_LITE_ADDR_WIDTH (64),
        .AXI_LITE_RESP_WIDTH (2),
        .DEST_CHIPID         (14'd3),
        .DEST_X              (8'd1),
        .DEST_Y              (8'd2),
        .SRC_CHIPID          (14'd5),
        .SRC_X               (8'd4),
        .SRC_Y               (8'd6)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axi_araddr             (s_axi_araddr),
        .s_axi_arvalid            (s_axi_arvalid),
        .s_axi_arready            (s_axi_arready),
        .s_axi_awaddr             (s_axi_awaddr),
        .s_axi_awvalid            (s_axi_awvalid),
        .s_axi_awready            (s_axi_awready),
        .s_axi_wdata              (s_axi_wdata),
        .s_axi_wstrb              (s_axi_wstrb),
        .s_axi_wvalid             (s_axi_wvalid),
        .s_axi_wready             (s_axi_wready),
        .noc_valid_out            (noc_valid_out),
        .noc_data_out             (noc_data_out),
        .noc_ready_in             (noc_ready_in),
        .transaction_type_wr_data (transaction_type_wr_data),
        .transaction_type_wr      (transaction_type_wr),
        .type_fifo_full           (type_fifo_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted flits and tag pushes mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (noc_valid_out && noc_ready_in) begin
                flits.push_back(noc_data_out);
                flit_cyc.push_back(cyc);
            end
            if (transaction_type_wr) begin
                tags.push_back(transaction_type_wr_data);
                tag_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr1(input logic [39:0] a, input logic [2:0] sz);
        return (64'(sz) << 56) | (64'(a) << 8);
    endfunction

    task automatic clear_logs();
        flits.delete();
        flit_cyc.delete();
        tags.delete();
        tag_cyc.delete();
    endtask

    task automatic send_ar(input logic [63:0] a);
        int t = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        chk("ar_hs", 64'(t < 200), 64'd1);
    endtask

    task automatic send_aw(input logic [63:0] a);
        int t = 0;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_awready && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        chk("aw_hs", 64'(t < 200), 64'd1);
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        int t = 0;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_wready && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        chk("w_hs", 64'(t < 200), 64'd1);
    endtask

    task automatic wait_flits(input int n);
        int t = 0;
        while (flits.size() < n && t < 300) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        #1;
        chk("flit_cnt", 64'(flits.size()), 64'(n));
    endtask

    initial begin
        int t;
        int rel;
        rst = 1'b1;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata  = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
        noc_ready_in = 1'b1;
        type_fifo_full = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_valid", 64'(noc_valid_out), 64'd0);
        chk("rst_data", noc_data_out, 64'd0);
        chk("rst_tagwr", 64'(transaction_type_wr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_arready", 64'(s_axi_arready), 64'd1);

        // Single read
        clear_logs();
        send_ar(64'h8000_0008);
        wait_flits(3);
        chk("rd_h0", flits[0], H0_LOAD);
        chk("rd_h1", flits[1], 64'h0400_0080_0000_0800);
        chk("rd_h2", flits[2], H2);
        chk("rd_ntag", 64'(tags.size()), 64'd1);
        chk("rd_tag", 64'(tags[0]), 64'd3);
        chk("rd_lat", 64'(flit_cyc[0] - tag_cyc[0]), 64'd1);
        chk("rd_back2back", 64'(flit_cyc[2] - flit_cyc[0]), 64'd2);

        // Write, W before AW
        clear_logs();
        send_w(64'h0102_0304_0506_0708, 8'hFF);
        send_aw(64'h1000);
        wait_flits(4);
        chk("wr_h0", flits[0], H0_STORE);
        chk("wr_h1", flits[1], 64'h0400_0000_0010_0000);
        chk("wr_h2", flits[2], H2);
        chk("wr_data", flits[3], 64'h0807_0605_0403_0201);
        chk("wr_ntag", 64'(tags.size()), 64'd1);
        chk("wr_tag", 64'(tags[0]), 64'd4);

        // Simultaneous AR and AW+W, twice: round-robin alternates
        clear_logs();
        fork
            begin send_ar(64'h40); send_ar(64'h48); end
            begin send_aw(64'h200); send_aw(64'h208); end
            begin send_w(64'h1111, 8'hFF); send_w(64'h2222, 8'hFF); end
        join
        wait_flits(14);
        chk("rr_ntag", 64'(tags.size()), 64'd4);
        chk("rr_p0", flits[0], H0_LOAD);
        chk("rr_p1", flits[3], H0_STORE);
        chk("rr_p2", flits[7], H0_LOAD);
        chk("rr_p3", flits[10], H0_STORE);
        chk("rr_tag0", 64'(tags[0]), 64'd2);
        chk("rr_tag1", 64'(tags[1]), 64'd4);
        chk("rr_tag2", 64'(tags[2]), 64'd3);
        chk("rr_tag3", 64'(tags[3]), 64'd5);
        chk("rr_p3_h1", flits[11], hdr1(40'h208, 3'b100));

        // Backpressure for 5 cycles while HDR1 is presented
        clear_logs();
        send_ar(64'h1238);
        t = 0;
        while (!(noc_valid_out && noc_data_out == hdr1(40'h1238, 3'b100)) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("hold_reach", 64'(t < 50), 64'd1);
        noc_ready_in = 1'b0;
        rel = tags.size();
        repeat (5) begin
            @(negedge clk);
            chk("hold_vld", 64'(noc_valid_out), 64'd1);
            chk("hold_data", noc_data_out, hdr1(40'h1238, 3'b100));
        end
        chk("hold_tag", 64'(tags.size()), 64'(rel));
        @(posedge clk); #1;
        noc_ready_in = 1'b1;
        wait_flits(3);
        chk("hold_f0", flits[0], H0_LOAD);
        chk("hold_f1", flits[1], hdr1(40'h1238, 3'b100));
        chk("hold_f2", flits[2], H2);
        chk("hold_ntag", 64'(tags.size()), 64'd1);

        // Tag fifo full blocks issue
        clear_logs();
        type_fifo_full = 1'b1;
        send_ar(64'h2000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_flits", 64'(flits.size()), 64'd0);
        chk("full_tags", 64'(tags.size()), 64'd0);
        chk("full_vld", 64'(noc_valid_out), 64'd0);
        @(posedge clk); #1;
        type_fifo_full = 1'b0;
        rel = cyc;
        wait_flits(3);
        chk("full_rel_tag", 64'(tag_cyc.size() > 0 ? tag_cyc[0] : -1), 64'(rel));
        chk("full_rel_flit", 64'(flit_cyc.size() > 0 ? flit_cyc[0] : -1), 64'(rel + 1));

        // Byte-mask store
        clear_logs();
        send_w(64'hAABB, 8'h0C);
        send_aw(64'h100);
        wait_flits(4);
`ifdef AXILITE_NOC_REQ_BYTEMASK_EN
        chk("bm_h1", flits[1], 64'h0200_0000_0001_0200);
`else
        chk("bm_h1", flits[1], 64'h0400_0000_0001_0000);
`endif

        // wstrb == 0 still issues a full 8B store
        clear_logs();
        send_w(64'h55, 8'h00);
        send_aw(64'h300);
        wait_flits(4);
        chk("z_h0", flits[0], H0_STORE);
        chk("z_h1", flits[1], 64'h0400_0000_0003_0000);

        // Reset mid-packet drops everything
        clear_logs();
        send_ar(64'h500);
        t = 0;
        while (!noc_valid_out && t < 50) begin @(posedge clk); #1; t++; end
        chk("mid_reach", 64'(t < 50), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_vld", 64'(noc_valid_out), 64'd0);
        chk("mid_data", noc_data_out, 64'd0);
        chk("mid_arready", 64'(s_axi_arready), 64'd0);
        rst = 1'b0;
        clear_logs();
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_flits", 64'(flits.size()), 64'd0);
        chk("mid_no_tags", 64'(tags.size()), 64'd0);
        chk("mid_arready_back", 64'(s_axi_arready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
